// File: rtl/blink_timer_pkg.sv
// Package blink_timer_pkg
// Purpose: shared mode codes and per-channel FSM state encodings for the
//          multi-channel blink timer.
// Contents: MODE_TOGGLE/PULSE/PWM/ONESHOT (2-bit), state_t {ST_IDLE, ST_RUN, ST_DONE}.
package blink_timer_pkg;

    localparam logic [1:0] MODE_TOGGLE  = 2'b00;
    localparam logic [1:0] MODE_PULSE   = 2'b01;
    localparam logic [1:0] MODE_PWM     = 2'b10;
    localparam logic [1:0] MODE_ONESHOT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/blink_timer_channel.sv
// Module blink_timer_channel
// Purpose: one blink channel -- counter, shadowed mode/period/duty, control FSM
//          and the registered output.
// Ports:
//   clk      in   system clock
//   rstb     in   asynchronous active-low reset
//   tick     in   count enable (1 every clk, or the shared prescaler strobe)
//   ena      in   channel enable; low clears the channel on the next edge
//   mode     in   2-bit mode (toggle / pulse / pwm / oneshot)
//   cnt_max  in   period P in ticks
//   duty     in   duty D in ticks
//   out      out  registered channel output
//   wrap     out  1-clk strobe on counter wrap P-1 -> 0
//   run      out  channel is in ST_RUN
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | cleared; waits for ena=1 with P!=0, then loads shadows
// ST_RUN  | counting ticks, output driven according to the shadowed mode
// ST_DONE | oneshot finished, output low; leaves only when ena drops
module blink_timer_channel
    import blink_timer_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             tick,
    input  logic             ena,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] cnt_max,
    input  logic [CNT_W-1:0] duty,
    output logic             out,
    output logic             wrap,
    output logic             run
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] per_s, per_nxt;
    logic [CNT_W-1:0] duty_s, duty_nxt;
    logic [1:0]       mode_s, mode_nxt;
    logic             out_nxt, wrap_nxt;
    logic             at_end;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            per_s  <= '0;
            duty_s <= '0;
            mode_s <= MODE_TOGGLE;
            out    <= 1'b0;
            wrap   <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            per_s  <= per_nxt;
            duty_s <= duty_nxt;
            mode_s <= mode_nxt;
            out    <= out_nxt;
            wrap   <= wrap_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        per_nxt   = per_s;
        duty_nxt  = duty_s;
        mode_nxt  = mode_s;
        out_nxt   = out;
        wrap_nxt  = 1'b0;
        at_end    = (cnt == per_s - ONE);

        if (!ena) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
            out_nxt   = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    out_nxt = 1'b0;
                    if (cnt_max != '0) begin
                        mode_nxt = mode;
                        per_nxt  = cnt_max;
                        duty_nxt = duty;
                        cnt_nxt  = '0;
                        // counter starts at 0, so PWM and oneshot are high iff D>0
                        if (mode == MODE_PWM || mode == MODE_ONESHOT)
                            out_nxt = (duty != '0);
                        if (mode == MODE_ONESHOT && duty == '0)
                            state_nxt = ST_DONE;
                        else
                            state_nxt = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (mode_s == MODE_PULSE)
                        out_nxt = 1'b0;
                    if (tick) begin
                        if (mode_s == MODE_ONESHOT && cnt == duty_s - ONE) begin
                            state_nxt = ST_DONE;
                            out_nxt   = 1'b0;
                        end else if (at_end) begin
                            // period boundary: the only point where config is re-sampled
                            wrap_nxt = 1'b1;
                            cnt_nxt  = '0;
                            mode_nxt = mode;
                            per_nxt  = cnt_max;
                            duty_nxt = duty;
                            if (cnt_max == '0) begin
                                state_nxt = ST_IDLE;
                                out_nxt   = 1'b0;
                            end else begin
                                case (mode)
                                    MODE_TOGGLE: out_nxt = ~out;
                                    MODE_PULSE:  out_nxt = 1'b1;
                                    MODE_PWM:    out_nxt = (duty != '0);
                                    default:     out_nxt = out;
                                endcase
                            end
                        end else begin
                            cnt_nxt = cnt + ONE;
                            if (mode_s == MODE_PWM)
                                out_nxt = ((cnt + ONE) < duty_s);
                        end
                    end
                end
                ST_DONE: out_nxt = 1'b0;
                default: begin
                    state_nxt = ST_IDLE;
                    out_nxt   = 1'b0;
                end
            endcase
        end
    end

    assign run = (state == ST_RUN);

endmodule

// File: rtl/multi_channel_blink_timer.sv
// Module multi_channel_blink_timer
// Purpose: N-channel LED blink timer; each channel independently runs toggle,
//          pulse, PWM or oneshot with shadowed period/duty.
// Optional feature: BLINK_PRESCALER_EN adds a shared tick prescaler; without it
//          every clk is a tick and i_prescale is ignored.
// Ports:
//   clk        in   system clock
//   rstb       in   asynchronous active-low reset
//   i_ena      in   per-channel enable
//   i_mode     in   per-channel mode, ch k at [2k+1:2k]
//   i_cntMax   in   per-channel period, ch k at [k*CNT_W +: CNT_W]
//   i_duty     in   per-channel duty, same packing
//   i_prescale in   tick divider (tick every i_prescale+1 clks)
//   o_out      out  registered channel outputs
//   o_wrap     out  per-channel 1-clk wrap strobe
//   o_busy     out  any channel running
module multi_channel_blink_timer
    import blink_timer_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int CNT_W = 32,
    parameter int PRE_W = 16
) (
    input  logic                  clk,
    input  logic                  rstb,
    input  logic [N_CH-1:0]       i_ena,
    input  logic [2*N_CH-1:0]     i_mode,
    input  logic [N_CH*CNT_W-1:0] i_cntMax,
    input  logic [N_CH*CNT_W-1:0] i_duty,
    input  logic [PRE_W-1:0]      i_prescale,
    output logic [N_CH-1:0]       o_out,
    output logic [N_CH-1:0]       o_wrap,
    output logic                  o_busy
);

    logic            tick;
    logic [N_CH-1:0] run;

`ifdef BLINK_PRESCALER_EN
    logic [PRE_W-1:0] pre_cnt;

    // >= rather than == so lowering i_prescale below pre_cnt cannot stall ticks
    assign tick = (pre_cnt >= i_prescale);

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb)
            pre_cnt <= '0;
        else if (i_ena == '0 || tick)
            pre_cnt <= '0;
        else
            pre_cnt <= pre_cnt + PRE_W'(1);
    end
`else
    logic unused_prescale;
    assign unused_prescale = ^i_prescale;
    assign tick = 1'b1;
`endif

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        blink_timer_channel #(.CNT_W(CNT_W)) u_ch (
            .clk     (clk),
            .rstb    (rstb),
            .tick    (tick),
            .ena     (i_ena[k]),
            .mode    (i_mode[2*k +: 2]),
            .cnt_max (i_cntMax[k*CNT_W +: CNT_W]),
            .duty    (i_duty[k*CNT_W +: CNT_W]),
            .out     (o_out[k]),
            .wrap    (o_wrap[k]),
            .run     (run[k])
        );
    end

    assign o_busy = |run;

endmodule

// File: tb/tb_multi_channel_blink_timer.sv
// Testbench for multi_channel_blink_timer: directed per-cycle vectors pushed
// into a scoreboard queue, compared by an independent monitor after each edge.
module tb_multi_channel_blink_timer;
    import blink_timer_pkg::*;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int PW = 16;

    logic            clk = 1'b0;
    logic            rstb;
    logic [N-1:0]    i_ena;
    logic [2*N-1:0]  i_mode;
    logic [N*W-1:0]  i_cntMax;
    logic [N*W-1:0]  i_duty;
    logic [PW-1:0]   i_prescale;
    logic [N-1:0]    o_out;
    logic [N-1:0]    o_wrap;
    logic            o_busy;

    multi_channel_blink_timer #(.N_CH(N), .CNT_W(W), .PRE_W(PW)) dut (
        .clk        (clk),
        .rstb       (rstb),
        .i_ena      (i_ena),
        .i_mode     (i_mode),
        .i_cntMax   (i_cntMax),
        .i_duty     (i_duty),
        .i_prescale (i_prescale),
        .o_out      (o_out),
        .o_wrap     (o_wrap),
        .o_busy     (o_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] out;
        logic [N-1:0] wrap;
        logic         busy;
        int           tid;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   tid      = 0;

    // monitor: one expectation per clock edge, checked 1 time unit after it
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (o_out !== e.out) begin
                    failures++;
                    $display("FAIL t%0d out actual=%b required=%b @%0t", e.tid, o_out, e.out, $time);
                end
                checks++;
                if (o_wrap !== e.wrap) begin
                    failures++;
                    $display("FAIL t%0d wrap actual=%b required=%b @%0t", e.tid, o_wrap, e.wrap, $time);
                end
                checks++;
                if (o_busy !== e.busy) begin
                    failures++;
                    $display("FAIL t%0d busy actual=%b required=%b @%0t", e.tid, o_busy, e.busy, $time);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    function automatic logic [N-1:0] bit_at(input int ch, input logic b);
        logic [N-1:0] v;
        v     = '0;
        v[ch] = b;
        return v;
    endfunction

    task automatic step(input logic [N-1:0] eo, input logic [N-1:0] ew, input logic eb);
        exp_t e;
        e.out  = eo;
        e.wrap = ew;
        e.busy = eb;
        e.tid  = tid;
        q.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_cfg(input int ch, input logic [1:0] m, input logic [W-1:0] p, input logic [W-1:0] d);
        i_mode[2*ch +: 2]  = m;
        i_cntMax[ch*W +: W] = p;
        i_duty[ch*W +: W]   = d;
    endtask

    initial begin
        logic [N-1:0] vo, vw;
        rstb       = 1'b0;
        i_ena      = '0;
        i_mode     = '0;
        i_cntMax   = '0;
        i_duty     = '0;
        i_prescale = '0;
        @(negedge clk);

        // reset state
        tid = 0;
        step('0, '0, 1'b0);
        step('0, '0, 1'b0);
        rstb = 1'b1;
        step('0, '0, 1'b0);

        // t1: toggle P=4 on ch0
        tid = 1;
        set_cfg(0, MODE_TOGGLE, 4, 0);
        i_ena[0] = 1'b1;
        for (int k = 0; k < 12; k++)
            step(bit_at(0, ((k/4)%2) == 1), bit_at(0, k > 0 && k%4 == 0), 1'b1);
        i_ena[0] = 1'b0;
        step('0, '0, 1'b0);

        // t2: PWM P=10 D=3, then D=0, then D=12 (changes mid-period wait for wrap)
        tid = 2;
        set_cfg(1, MODE_PWM, 10, 3);
        i_ena[1] = 1'b1;
        for (int k = 0; k < 40; k++) begin
            logic o;
            if (k == 15) set_cfg(1, MODE_PWM, 10, 0);
            if (k == 22) set_cfg(1, MODE_PWM, 10, 12);
            o = (k < 20) ? ((k%10) < 3) : (k < 30) ? 1'b0 : 1'b1;
            step(bit_at(1, o), bit_at(1, k > 0 && k%10 == 0), 1'b1);
        end
        i_ena[1] = 1'b0;
        step('0, '0, 1'b0);

        // t3: oneshot D=5, re-arm by ena cycle, then D=0
        tid = 3;
        set_cfg(2, MODE_ONESHOT, 100, 5);
        i_ena[2] = 1'b1;
        for (int k = 0; k < 10; k++)
            step(bit_at(2, k < 5), '0, k < 5);
        i_ena[2] = 1'b0;
        step('0, '0, 1'b0);
        i_ena[2] = 1'b1;
        for (int k = 0; k < 7; k++)
            step(bit_at(2, k < 5), '0, k < 5);
        i_ena[2] = 1'b0;
        step('0, '0, 1'b0);
        set_cfg(2, MODE_ONESHOT, 100, 0);
        i_ena[2] = 1'b1;
        step('0, '0, 1'b0);
        step('0, '0, 1'b0);
        i_ena[2] = 1'b0;
        step('0, '0, 1'b0);

        // t4: toggle P=8, P->2 at cnt=3; old period completes first
        tid = 4;
        set_cfg(3, MODE_TOGGLE, 8, 0);
        i_ena[3] = 1'b1;
        for (int k = 0; k < 16; k++) begin
            if (k == 4) set_cfg(3, MODE_TOGGLE, 2, 0);
            step(bit_at(3, k >= 8 && ((k-8)/2)%2 == 0), bit_at(3, k >= 8 && (k-8)%2 == 0), 1'b1);
        end
        i_ena[3] = 1'b0;
        step('0, '0, 1'b0);

        // t5: reset mid-run at cnt=5; restart from 0 only after ena rises
        tid = 5;
        set_cfg(0, MODE_TOGGLE, 8, 0);
        i_ena[0] = 1'b1;
        for (int k = 0; k < 6; k++)
            step('0, '0, 1'b1);
        rstb  = 1'b0;
        i_ena = '0;
        step('0, '0, 1'b0);
        step('0, '0, 1'b0);
        rstb = 1'b1;
        step('0, '0, 1'b0);
        step('0, '0, 1'b0);
        i_ena[0] = 1'b1;
        for (int k = 0; k < 9; k++)
            step(bit_at(0, k == 8), bit_at(0, k == 8), 1'b1);
        i_ena[0] = 1'b0;
        step('0, '0, 1'b0);

        // t7: ch1 enabled on the edge ch0 wraps; channels independent
        tid = 7;
        set_cfg(0, MODE_TOGGLE, 2, 0);
        set_cfg(1, MODE_PULSE, 3, 0);
        i_ena[0] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (k == 2) i_ena[1] = 1'b1;
            vo    = '0;
            vw    = '0;
            vo[0] = ((k/2)%2) == 1;
            vw[0] = k > 0 && k%2 == 0;
            vo[1] = k > 2 && (k-2)%3 == 0;
            vw[1] = vo[1];
            step(vo, vw, 1'b1);
        end
        i_ena = '0;
        step('0, '0, 1'b0);

        // t8: P=0 never starts; reload of P=0 at a wrap returns to idle
        tid = 8;
        set_cfg(0, MODE_TOGGLE, 0, 0);
        i_ena[0] = 1'b1;
        step('0, '0, 1'b0);
        i_ena[0] = 1'b0;
        step('0, '0, 1'b0);
        set_cfg(0, MODE_TOGGLE, 3, 0);
        i_ena[0] = 1'b1;
        step('0, '0, 1'b1);
        set_cfg(0, MODE_TOGGLE, 0, 0);
        step('0, '0, 1'b1);
        step('0, '0, 1'b1);
        step('0, bit_at(0, 1'b1), 1'b0);
        step('0, '0, 1'b0);
        i_ena[0] = 1'b0;
        step('0, '0, 1'b0);

`ifdef BLINK_PRESCALER_EN
        // t6: prescale=2, pulse P=2 -> wrap every 6 clks, 1 clk wide
        tid = 6;
        i_prescale = 2;
        set_cfg(0, MODE_PULSE, 2, 0);
        i_ena[0] = 1'b1;
        for (int k = 0; k < 18; k++)
            step(bit_at(0, k%6 == 5), bit_at(0, k%6 == 5), 1'b1);
        i_ena[0]   = 1'b0;
        i_prescale = 0;
        step('0, '0, 1'b0);
`endif

        for (int i = 0; i < 10 && q.size() > 0; i++)
            @(negedge clk);
        checks++;
        if (q.size() > 0) begin
            failures++;
            $display("FAIL drain pending actual=%0d required=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
